// File: rtl/cbus_arbiter_n_if.sv
// CBus payload types and the N-master arbiter bus bundle (upstream requests/responses
// plus the single downstream port).
package cbus_arbiter_n_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 4;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;
endpackage

interface cbus_arbiter_n_if #(
  parameter int unsigned NUM_MASTERS = 2
);
  import cbus_arbiter_n_pkg::*;

  cbus_req_t  ireqs  [NUM_MASTERS];
  cbus_resp_t iresps [NUM_MASTERS];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  // slave: the arbiter; master: the surrounding masters plus downstream responder
  modport slave  (input  ireqs, input  oresp, output iresps, output oreq);
  modport master (output ireqs, output oresp, input  iresps, input  oreq);
endinterface

// File: rtl/cbus_arbiter_n.sv
// N-master CBus arbiter: grants one upstream master per burst, holds it until last.
// Define CBUS_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
module cbus_arbiter_n
  import cbus_arbiter_n_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned SEL_W       = $clog2(NUM_MASTERS)
) (
  input  logic                clk,
  input  logic                reset,
  cbus_arbiter_n_if.slave     bus,
  output logic                busy,
  output logic [SEL_W-1:0]    grant_id
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             found_c;
  logic [SEL_W-1:0] winner_c;
`ifdef CBUS_ARB_RR_EN
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

  // Winner search; the round-robin pass only considers indices at or above rr_ptr
  always_comb begin
    found_c  = 1'b0;
    winner_c = '0;
`ifdef CBUS_ARB_RR_EN
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (!found_c && bus.ireqs[i].valid && (SEL_W'(i) >= rr_ptr_q)) begin
        found_c  = 1'b1;
        winner_c = SEL_W'(i);
      end
    end
`endif
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (!found_c && bus.ireqs[i].valid) begin
        found_c  = 1'b1;
        winner_c = SEL_W'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
`ifdef CBUS_ARB_RR_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d = BUSY;
          sel_d   = winner_c;
        end
      end
      BUSY: begin
        if (bus.oresp.ready && bus.oresp.last) begin
          state_d = IDLE;
`ifdef CBUS_ARB_RR_EN
          rr_ptr_d = (sel_q == SEL_W'(NUM_MASTERS - 1)) ? '0 : sel_q + SEL_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == BUSY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      busy_q   <= 1'b0;
`ifdef CBUS_ARB_RR_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
`ifdef CBUS_ARB_RR_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  // Combinational beat path between the granted master and the downstream port
  always_comb begin
    bus.oreq = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      bus.iresps[i] = '0;
    end
    if (state_q == BUSY) begin
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
        if (SEL_W'(i) == sel_q) begin
          bus.oreq      = bus.ireqs[i];
          bus.iresps[i] = bus.oresp;
        end
      end
    end
  end

  assign busy     = busy_q;
  assign grant_id = sel_q;

endmodule

// File: tb/tb_cbus_arbiter_n.sv
// Directed bench for cbus_arbiter_n: table-driven 4-master vectors plus hand sequences
// for a 2-master burst and a 5-master asynchronous reset / pointer wrap.
module tb_cbus_arbiter_n;
  import cbus_arbiter_n_pkg::*;

`ifdef CBUS_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic       last;
    logic       e_busy;
    logic [1:0] e_gid;
    logic [3:0] e_rdy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rst5_n;
  logic       busy2, busy4, busy5;
  logic [0:0] gid2;
  logic [1:0] gid4;
  logic [2:0] gid5;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];

  cbus_arbiter_n_if #(.NUM_MASTERS(2)) bus2 ();
  cbus_arbiter_n_if #(.NUM_MASTERS(4)) bus4 ();
  cbus_arbiter_n_if #(.NUM_MASTERS(5)) bus5 ();

  cbus_arbiter_n #(.NUM_MASTERS(2)) dut2 (
    .clk(clk), .reset(rst_n), .bus(bus2.slave), .busy(busy2), .grant_id(gid2));
  cbus_arbiter_n #(.NUM_MASTERS(4)) dut4 (
    .clk(clk), .reset(rst_n), .bus(bus4.slave), .busy(busy4), .grant_id(gid4));
  cbus_arbiter_n #(.NUM_MASTERS(5)) dut5 (
    .clk(clk), .reset(rst5_n), .bus(bus5.slave), .busy(busy5), .grant_id(gid5));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [3:0] req, input logic rdy, input logic last,
                              input logic b, input logic [1:0] g);
    vec_t v;
    v.req    = req;
    v.rdy    = rdy;
    v.last   = last;
    v.e_busy = b;
    v.e_gid  = g;
    v.e_rdy  = b ? 4'(4'b0001 << g) : 4'b0000;
    tbl.push_back(v);
  endfunction

  function automatic logic [31:0] addr_of(input int i);
    return 32'((i + 1) * 256);
  endfunction

  initial begin
    logic [3:0] rm, lm;
    bit         b;
    int         g;
    vec_t       r;

    // Vector table for the 4-master instance
    for (int k = 0; k < 12; k++) begin
      b = (k % 2 == 1);
      g = RR_EN ? ((k - 1) / 2) % 4 : 0;
      add(4'b1111, 1'b1, 1'b1, b, 2'(g));
    end
    add(4'b0000, 1'b1, 1'b1, 1'b0, 2'd0);
    for (int k = 0; k < 8; k++) begin
      b = (k % 2 == 1);
      g = RR_EN ? ((((k - 1) / 2) % 2 == 0) ? 2 : 0) : 0;
      add(4'b0101, 1'b1, 1'b1, b, 2'(g));
    end
    add(4'b0000, 1'b1, 1'b1, 1'b0, 2'd0);
    add(4'b0001, 1'b1, 1'b0, 1'b0, 2'd0);
    add(4'b0001, 1'b1, 1'b0, 1'b1, 2'd0);
    for (int k = 2; k <= 7; k++) add(4'b0011, 1'b1, 1'b0, 1'b1, 2'd0);
    add(4'b0011, 1'b1, 1'b1, 1'b1, 2'd0);
    add(4'b0010, 1'b1, 1'b0, 1'b0, 2'd0);
    add(4'b0010, 1'b1, 1'b1, 1'b1, 2'd1);
    add(4'b0000, 1'b1, 1'b1, 1'b0, 2'd0);

    rst_n  = 1'b0;
    rst5_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus2.ireqs[i] = '0;
      bus2.ireqs[i].addr = 32'h2000 + addr_of(i);
    end
    for (int i = 0; i < 4; i++) begin
      bus4.ireqs[i] = '0;
      bus4.ireqs[i].addr = addr_of(i);
      bus4.ireqs[i].valid = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      bus5.ireqs[i] = '0;
      bus5.ireqs[i].addr = 32'h5000 + addr_of(i);
    end
    bus2.oresp = '0;
    bus4.oresp = '{ready: 1'b1, last: 1'b1, data: 32'hFFFF};
    bus5.oresp = '0;

    // Reset state with requests and responses active
    #2;
    chk("rst busy", 32'(busy4), 32'd0);
    chk("rst grant_id", 32'(gid4), 32'd0);
    chk("rst oreq", 32'(bus4.oreq != '0), 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst iresps[%0d]", i), 32'(bus4.iresps[i] != '0), 32'd0);

    @(negedge clk);
    for (int i = 0; i < 4; i++) bus4.ireqs[i].valid = 1'b0;
    rst_n  = 1'b1;
    rst5_n = 1'b1;

    // Table-driven vectors: inputs held for one cycle, outputs sampled mid-cycle
    for (int k = 0; k < tbl.size(); k++) begin
      r = tbl[k];
      @(negedge clk);
      for (int i = 0; i < 4; i++) bus4.ireqs[i].valid = r.req[i];
      bus4.oresp.ready = r.rdy;
      bus4.oresp.last  = r.last;
      bus4.oresp.data  = 32'(k);
      #1;
      for (int i = 0; i < 4; i++) begin
        rm[i] = bus4.iresps[i].ready;
        lm[i] = bus4.iresps[i].last;
      end
      chk($sformatf("v%0d busy", k), 32'(busy4), 32'(r.e_busy));
      chk($sformatf("v%0d oreq.valid", k), 32'(bus4.oreq.valid), 32'(r.e_busy));
      chk($sformatf("v%0d oreq.addr", k), bus4.oreq.addr, r.e_busy ? addr_of(int'(r.e_gid)) : 32'd0);
      chk($sformatf("v%0d ready mask", k), 32'(rm), 32'(r.e_rdy));
      chk($sformatf("v%0d last mask", k), 32'(lm), r.last ? 32'(r.e_rdy) : 32'd0);
      if (r.e_busy) begin
        chk($sformatf("v%0d grant_id", k), 32'(gid4), 32'(r.e_gid));
        chk($sformatf("v%0d resp data", k), bus4.iresps[r.e_gid].data, 32'(k));
      end
    end

    // Two masters: master 1 runs a 4-beat read
    @(negedge clk);
    bus2.ireqs[1].valid = 1'b1;
    bus2.ireqs[1].len   = 4'd3;
    bus2.oresp.ready    = 1'b1;
    #1;
    chk("n2 req cycle oreq.valid", 32'(bus2.oreq.valid), 32'd0);
    chk("n2 req cycle busy", 32'(busy2), 32'd0);
    for (int beat = 1; beat <= 4; beat++) begin
      @(negedge clk);
      bus2.oresp.last = (beat == 4);
      bus2.oresp.data = 32'hA0 + 32'(beat);
      #1;
      chk($sformatf("n2 b%0d oreq.valid", beat), 32'(bus2.oreq.valid), 32'd1);
      chk($sformatf("n2 b%0d oreq.addr", beat), bus2.oreq.addr, 32'h2000 + addr_of(1));
      chk($sformatf("n2 b%0d oreq.len", beat), 32'(bus2.oreq.len), 32'd3);
      chk($sformatf("n2 b%0d grant_id", beat), 32'(gid2), 32'd1);
      chk($sformatf("n2 b%0d iresps1.ready", beat), 32'(bus2.iresps[1].ready), 32'd1);
      chk($sformatf("n2 b%0d iresps1.last", beat), 32'(bus2.iresps[1].last), 32'(beat == 4));
      chk($sformatf("n2 b%0d iresps1.data", beat), bus2.iresps[1].data, 32'hA0 + 32'(beat));
      chk($sformatf("n2 b%0d iresps0 zero", beat), 32'(bus2.iresps[0] != '0), 32'd0);
    end
    @(negedge clk);
    bus2.ireqs[1].valid = 1'b0;
    #1;
    chk("n2 after last busy", 32'(busy2), 32'd0);
    chk("n2 after last oreq.valid", 32'(bus2.oreq.valid), 32'd0);
    chk("n2 after last iresps1.ready", 32'(bus2.iresps[1].ready), 32'd0);

    // Five masters: asynchronous reset at beat 3 of master 2's burst
    @(negedge clk);
    bus5.ireqs[2].valid = 1'b1;
    bus5.oresp.ready    = 1'b1;
    bus5.oresp.last     = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("n5 b3 busy", 32'(busy5), 32'd1);
    chk("n5 b3 grant_id", 32'(gid5), 32'd2);
    #1;
    rst5_n = 1'b0;
    #1;
    chk("n5 async rst oreq.valid", 32'(bus5.oreq.valid), 32'd0);
    chk("n5 async rst busy", 32'(busy5), 32'd0);
    chk("n5 async rst grant_id", 32'(gid5), 32'd0);
    for (int i = 0; i < 5; i++) chk($sformatf("n5 async rst iresps[%0d]", i), 32'(bus5.iresps[i] != '0), 32'd0);
    @(negedge clk);
    rst5_n = 1'b1;
    bus5.ireqs[2].valid = 1'b0;
    bus5.ireqs[3].valid = 1'b1;
    #1;
    chk("n5 post-rst idle busy", 32'(busy5), 32'd0);
    @(negedge clk);
    bus5.oresp.last = 1'b1;
    #1;
    chk("n5 m3 busy", 32'(busy5), 32'd1);
    chk("n5 m3 grant_id", 32'(gid5), 32'd3);
    chk("n5 m3 oreq.addr", bus5.oreq.addr, 32'h5000 + addr_of(3));
    @(negedge clk);
    bus5.ireqs[3].valid = 1'b0;
    bus5.ireqs[0].valid = 1'b1;
    bus5.ireqs[4].valid = 1'b1;
    #1;
    chk("n5 gap busy", 32'(busy5), 32'd0);
    @(negedge clk);
    #1;
    chk("n5 second grant_id", 32'(gid5), RR_EN ? 32'd4 : 32'd0);
    chk("n5 second ready", 32'(bus5.iresps[RR_EN ? 4 : 0].ready), 32'd1);
    @(negedge clk);
    #1;
    chk("n5 gap2 busy", 32'(busy5), 32'd0);
    @(negedge clk);
    #1;
    chk("n5 wrap grant_id", 32'(gid5), 32'd0);
    chk("n5 wrap oreq.addr", bus5.oreq.addr, 32'h5000 + addr_of(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
